// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: arm, ring, snooze, auto-silence and re-arm, plus buzzer cadence.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl #(
  parameter int RING_MINUTES   = 5,
  parameter int SNOOZE_MINUTES = 9,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic       alarm_match,
  input  logic       alarm_enable,
  input  logic       snooze_button,
  input  logic       stop_button,
  input  logic       load_new_alarm,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [1:0] snooze_count
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [2:0] {IDLE, ARMED, RINGING, SNOOZE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARMED, RINGING, DONE} state_t;
`endif

  localparam logic [5:0] RING_TERM = 6'(RING_MINUTES);
  localparam logic [5:0] SNZ_TERM  = 6'(SNOOZE_MINUTES);
  localparam logic [1:0] MAX_SNZ   = 2'(MAX_SNOOZES);

  state_t     state, state_nx;
  logic       match_q, snz_q, stp_q;
  logic       match_rise, snz_rise, stp_rise;
  logic [5:0] ring_min, ring_min_nx;
  logic       buzzer_nx;

  assign match_rise = alarm_match & ~match_q;
  assign snz_rise   = snooze_button & ~snz_q;
  assign stp_rise   = stop_button & ~stp_q;

`ifdef ALARM_SNOOZE_EN
  logic [5:0] snz_min, snz_min_nx;
  logic [1:0] snz_cnt, snz_cnt_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snz_min <= 6'd0;
      snz_cnt <= 2'd0;
    end else begin
      snz_min <= snz_min_nx;
      snz_cnt <= snz_cnt_nx;
    end
  end

  assign snoozed      = (state == SNOOZE);
  assign snooze_count = snz_cnt;
`else
  logic unused_cfg;
  assign unused_cfg   = snz_rise ^ (^SNZ_TERM) ^ (^MAX_SNZ);
  assign snoozed      = 1'b0;
  assign snooze_count = 2'b00;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match_q  <= 1'b0;
      snz_q    <= 1'b0;
      stp_q    <= 1'b0;
      state    <= IDLE;
      ring_min <= 6'd0;
      buzzer   <= 1'b0;
    end else begin
      match_q  <= alarm_match;
      snz_q    <= snooze_button;
      stp_q    <= stop_button;
      state    <= state_nx;
      ring_min <= ring_min_nx;
      buzzer   <= buzzer_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ring_min_nx = ring_min;
`ifdef ALARM_SNOOZE_EN
    snz_min_nx  = snz_min;
    snz_cnt_nx  = snz_cnt;
`endif
    if (!alarm_enable || (load_new_alarm && state != IDLE)) begin
      state_nx    = alarm_enable ? ARMED : IDLE;
      ring_min_nx = 6'd0;
`ifdef ALARM_SNOOZE_EN
      snz_min_nx  = 6'd0;
      snz_cnt_nx  = 2'd0;
`endif
    end else begin
      case (state)
        IDLE: state_nx = ARMED;
        ARMED: begin
          if (match_rise) begin
            state_nx    = RINGING;
            ring_min_nx = 6'd0;
          end
        end
        RINGING: begin
          if (stp_rise) begin
            state_nx = DONE;
`ifdef ALARM_SNOOZE_EN
          end else if (snz_rise && snz_cnt < MAX_SNZ) begin
            state_nx   = SNOOZE;
            snz_cnt_nx = snz_cnt + 2'd1;
            snz_min_nx = 6'd0;
`endif
          end else if (one_minute) begin
            // Saturate on the terminal pulse; the same pulse ends the ring.
            if (ring_min >= RING_TERM - 6'd1) begin
              ring_min_nx = RING_TERM;
              state_nx    = DONE;
            end else begin
              ring_min_nx = ring_min + 6'd1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stp_rise) begin
            state_nx = DONE;
          end else if (one_minute) begin
            if (snz_min >= SNZ_TERM - 6'd1) begin
              snz_min_nx  = SNZ_TERM;
              state_nx    = RINGING;
              ring_min_nx = 6'd0;
            end else begin
              snz_min_nx = snz_min + 6'd1;
            end
          end
        end
`endif
        DONE: begin
          if (!alarm_match) begin
            state_nx = ARMED;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_nx = 2'd0;
`endif
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    buzzer_nx = 1'b0;
    if (state_nx == RINGING) begin
      buzzer_nx = (state == RINGING) ? (buzzer ^ one_second) : 1'b1;
    end
  end

  assign ringing = (state == RINGING);

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with a queue scoreboard of expected outputs.
module tb_alarm_ring_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second, one_minute, alarm_match, alarm_enable;
  logic       snooze_button, stop_button, load_new_alarm;
  logic       buzzer, ringing, snoozed;
  logic [1:0] snooze_count;

  int checks   = 0;
  int failures = 0;

`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_BUILD = 1'b1;
`else
  localparam bit SNZ_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       buz;
    logic       ring;
    logic       snz;
    logic [1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clock = ~clock;

  alarm_ring_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .one_second     (one_second),
    .one_minute     (one_minute),
    .alarm_match    (alarm_match),
    .alarm_enable   (alarm_enable),
    .snooze_button  (snooze_button),
    .stop_button    (stop_button),
    .load_new_alarm (load_new_alarm),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozed        (snoozed),
    .snooze_count   (snooze_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic b, input logic r,
                          input logic s, input logic [1:0] c);
    exp_t e;
    e.buz  = b;
    e.ring = r;
    e.snz  = s;
    e.cnt  = c;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (buzzer === e.buz) else begin
      failures++;
      $error("FAIL %s buzzer actual=%0b required=%0b", t, buzzer, e.buz);
    end
    checks++;
    assert (ringing === e.ring) else begin
      failures++;
      $error("FAIL %s ringing actual=%0b required=%0b", t, ringing, e.ring);
    end
    checks++;
    assert (snoozed === e.snz) else begin
      failures++;
      $error("FAIL %s snoozed actual=%0b required=%0b", t, snoozed, e.snz);
    end
    checks++;
    assert (snooze_count === e.cnt) else begin
      failures++;
      $error("FAIL %s snooze_count actual=%0d required=%0d", t, snooze_count, e.cnt);
    end
  endtask

  task automatic expect_after(input string tag, input int n, input logic b, input logic r,
                              input logic s, input logic [1:0] c);
    push_exp(tag, b, r, s, c);
    step(n);
    pop_check();
  endtask

  initial begin
    reset          = 1'b1;
    one_second     = 1'b0;
    one_minute     = 1'b0;
    alarm_match    = 1'b0;
    alarm_enable   = 1'b0;
    snooze_button  = 1'b0;
    stop_button    = 1'b0;
    load_new_alarm = 1'b0;
    step(3);
    push_exp("reset_state", 1'b0, 1'b0, 1'b0, 2'd0);
    pop_check();

    reset        = 1'b0;
    alarm_enable = 1'b1;
    expect_after("armed_quiet", 2, 1'b0, 1'b0, 1'b0, 2'd0);

    // Basic ring, buzzer cadence 1,0,1,0,1, then stop.
    alarm_match = 1'b1;
    expect_after("ring_start", 2, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      one_second = 1'b1;
      push_exp($sformatf("buzz_toggle_%0d", i), (i % 2) == 1, 1'b1, 1'b0, 2'd0);
      step(1);
      one_second = 1'b0;
      pop_check();
      expect_after($sformatf("buzz_hold_%0d", i), 1, (i % 2) == 1, 1'b1, 1'b0, 2'd0);
    end
    stop_button = 1'b1;
    expect_after("stop_done", 2, 1'b0, 1'b0, 1'b0, 2'd0);
    stop_button = 1'b0;
    expect_after("done_hold", 3, 1'b0, 1'b0, 1'b0, 2'd0);
    alarm_match = 1'b0;
    step(2);
    alarm_match = 1'b1;
    expect_after("rearm_ring", 2, 1'b1, 1'b1, 1'b0, 2'd0);

    // Auto-silence on the 5th minute pulse.
    for (int m = 1; m <= 5; m++) begin
      one_minute = 1'b1;
      push_exp($sformatf("silence_min_%0d", m), m < 5, m < 5, 1'b0, 2'd0);
      step(1);
      one_minute = 1'b0;
      pop_check();
      step(1);
    end
    expect_after("silence_match_high", 3, 1'b0, 1'b0, 1'b0, 2'd0);
    alarm_match = 1'b0;
    step(2);
    alarm_match = 1'b1;
    expect_after("ring_after_silence", 2, 1'b1, 1'b1, 1'b0, 2'd0);

    // Stop and snooze edges together: stop wins.
    stop_button   = 1'b1;
    snooze_button = 1'b1;
    expect_after("stop_and_snooze", 2, 1'b0, 1'b0, 1'b0, 2'd0);
    stop_button   = 1'b0;
    snooze_button = 1'b0;
    step(1);
    alarm_match = 1'b0;
    step(2);
    alarm_match = 1'b1;
    expect_after("ring_for_snooze", 2, 1'b1, 1'b1, 1'b0, 2'd0);

`ifdef ALARM_SNOOZE_EN
    for (int k = 1; k <= 3; k++) begin
      snooze_button = 1'b1;
      expect_after($sformatf("snooze_%0d", k), 2, 1'b0, 1'b0, 1'b1, 2'(k));
      snooze_button = 1'b0;
      step(1);
      for (int m = 1; m <= 9; m++) begin
        one_minute = 1'b1;
        push_exp($sformatf("snooze_%0d_min_%0d", k, m), m == 9, m == 9, m != 9, 2'(k));
        step(1);
        one_minute = 1'b0;
        pop_check();
        step(1);
      end
    end
    snooze_button = 1'b1;
    expect_after("snooze_limit", 2, 1'b1, 1'b1, 1'b0, 2'd3);
    snooze_button = 1'b0;
    step(1);
`else
    for (int k = 0; k < 4; k++) begin
      snooze_button = 1'b1;
      expect_after($sformatf("snooze_ignored_%0d", k), 2, 1'b1, 1'b1, 1'b0, 2'd0);
      snooze_button = 1'b0;
      step(1);
    end
`endif

    // Reload while ringing.
    load_new_alarm = 1'b1;
    push_exp("load_while_ring", 1'b0, 1'b0, 1'b0, 2'd0);
    step(1);
    load_new_alarm = 1'b0;
    pop_check();
    alarm_match = 1'b0;
    step(1);
    alarm_match = 1'b1;
    expect_after("ring_after_load", 2, 1'b1, 1'b1, 1'b0, 2'd0);

    // Disable from SNOOZE (or RINGING when snooze is not built).
    snooze_button = 1'b1;
    expect_after("snooze_before_disable", 2, !SNZ_BUILD, !SNZ_BUILD, SNZ_BUILD, {1'b0, SNZ_BUILD});
    snooze_button = 1'b0;
    alarm_enable  = 1'b0;
    expect_after("disable_idle", 1, 1'b0, 1'b0, 1'b0, 2'd0);

    alarm_enable = 1'b1;
    alarm_match  = 1'b0;
    step(2);
    alarm_match = 1'b1;
    expect_after("ring_before_reset", 2, 1'b1, 1'b1, 1'b0, 2'd0);

    // Asynchronous reset mid-ring, observed before any clock edge.
    reset = 1'b1;
    #1;
    push_exp("reset_mid_ring", 1'b0, 1'b0, 1'b0, 2'd0);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
